// File: rtl/event_window_ingress.sv
// event_window_ingress
// Front end for DVS events: drops out-of-range and non-monotonic events,
// re-stamps accepted events relative to the current accumulation window and
// buffers them in a show-ahead FIFO. A window closes only after everything
// stamped against it has left the FIFO, and window_done marks that moment.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | no window yet; the first good event opens one with dt=0
// ST_OPEN  | window open; in-window events are buffered with their dt
// ST_DRAIN | boundary event parked in pending regs; wait for FIFO to empty
// ST_START | window_done pulse; pending event opens the next window
module event_window_ingress #(
   parameter int MAX_X_COORD    = 240,
   parameter int MAX_Y_COORD    = 180,
   parameter int INPUT_BIT_TIME = 32,
   parameter int INPUT_BIT_X    = 8,
   parameter int INPUT_BIT_Y    = 8,
   parameter int WINDOW_US      = 50000,
   parameter int TIME_OUT_BIT   = 16,
   parameter int FIFO_DEPTH     = 16,
   parameter int CNT_BIT        = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [INPUT_BIT_TIME-1:0] timestamp,
   input  logic [INPUT_BIT_X-1:0]    x_coord,
   input  logic [INPUT_BIT_Y-1:0]    y_coord,
   input  logic                      polarity,
   input  logic                      is_valid,
   output logic                      in_ready,
   output logic [INPUT_BIT_X-1:0]    out_x,
   output logic [INPUT_BIT_Y-1:0]    out_y,
   output logic                      out_pol,
   output logic [TIME_OUT_BIT-1:0]   out_dt,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic                      window_done,
   output logic [CNT_BIT-1:0]        window_cnt,
   output logic [CNT_BIT-1:0]        drop_cnt
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int PW = AW + 1;
   localparam int EW = INPUT_BIT_X + INPUT_BIT_Y + 1 + TIME_OUT_BIT;
   localparam logic [INPUT_BIT_X:0]      X_LIM   = (INPUT_BIT_X + 1)'(MAX_X_COORD);
   localparam logic [INPUT_BIT_Y:0]      Y_LIM   = (INPUT_BIT_Y + 1)'(MAX_Y_COORD);
   localparam logic [INPUT_BIT_TIME-1:0] WIN_LIM = INPUT_BIT_TIME'(WINDOW_US);
   localparam logic [PW-1:0]             AFULL   = PW'(FIFO_DEPTH - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_OPEN, ST_DRAIN, ST_START} state_t;

   state_t                    state_q, state_d;
   logic [INPUT_BIT_TIME-1:0] win_start_q, win_start_d;
   logic [INPUT_BIT_TIME-1:0] pend_ts_q, pend_ts_d;
   logic [INPUT_BIT_X-1:0]    pend_x_q, pend_x_d;
   logic [INPUT_BIT_Y-1:0]    pend_y_q, pend_y_d;
   logic                      pend_pol_q, pend_pol_d;
   logic                      stg_v_q, stg_v_d;
   logic [EW-1:0]             stg_data_q, stg_data_d;
   logic [CNT_BIT-1:0]        win_cnt_q, win_cnt_d;
   logic [CNT_BIT-1:0]        drop_cnt_q, drop_cnt_d;
   logic                      rdy_en_q;
   logic [PW-1:0]             wr_ptr_q, rd_ptr_q;
   logic [EW-1:0]             mem_q [FIFO_DEPTH];

   logic                      fifo_empty, fifo_full, fifo_afull;
   logic [PW-1:0]             fifo_cnt;
   logic                      in_ready_c, accept, coord_bad, drop;
   logic [INPUT_BIT_TIME-1:0] delta;
   logic                      push, pop;
   logic [EW-1:0]             rd_data;

   assign fifo_cnt   = wr_ptr_q - rd_ptr_q;
   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   // The staging register is one write in flight, so it counts as occupancy.
   assign fifo_afull = (fifo_cnt == AFULL);

   assign in_ready_c = rdy_en_q && ((state_q == ST_IDLE) || (state_q == ST_OPEN)) &&
                       !fifo_full && !(stg_v_q && fifo_afull);
   assign accept     = is_valid && in_ready_c;
   assign coord_bad  = ({1'b0, x_coord} >= X_LIM) || ({1'b0, y_coord} >= Y_LIM);
   assign delta      = timestamp - win_start_q;

   // Window sequencing, filtering and staging of the next FIFO write.
   always_comb begin
      state_d     = state_q;
      win_start_d = win_start_q;
      pend_ts_d   = pend_ts_q;
      pend_x_d    = pend_x_q;
      pend_y_d    = pend_y_q;
      pend_pol_d  = pend_pol_q;
      stg_v_d     = 1'b0;
      stg_data_d  = stg_data_q;
      win_cnt_d   = win_cnt_q;
      drop        = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (coord_bad) begin
                  drop = 1'b1;
               end else begin
                  win_start_d = timestamp;
                  stg_v_d     = 1'b1;
                  stg_data_d  = {x_coord, y_coord, polarity, {TIME_OUT_BIT{1'b0}}};
                  state_d     = ST_OPEN;
               end
            end
         end
         ST_OPEN: begin
            if (accept) begin
               if (coord_bad || (timestamp < win_start_q)) begin
                  drop = 1'b1;
               end else if (delta < WIN_LIM) begin
                  stg_v_d    = 1'b1;
                  stg_data_d = {x_coord, y_coord, polarity, delta[TIME_OUT_BIT-1:0]};
               end else begin
                  pend_ts_d  = timestamp;
                  pend_x_d   = x_coord;
                  pend_y_d   = y_coord;
                  pend_pol_d = polarity;
                  state_d    = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            if (fifo_empty && !stg_v_q) state_d = ST_START;
         end
         ST_START: begin
            win_cnt_d   = win_cnt_q + 1'b1;
            win_start_d = pend_ts_q;
            stg_v_d     = 1'b1;
            stg_data_d  = {pend_x_q, pend_y_q, pend_pol_q, {TIME_OUT_BIT{1'b0}}};
            state_d     = ST_OPEN;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign drop_cnt_d = (drop && (drop_cnt_q != {CNT_BIT{1'b1}})) ? drop_cnt_q + 1'b1
                                                                 : drop_cnt_q;

   // Control and datapath registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         win_start_q <= '0;
         pend_ts_q   <= '0;
         pend_x_q    <= '0;
         pend_y_q    <= '0;
         pend_pol_q  <= 1'b0;
         stg_v_q     <= 1'b0;
         stg_data_q  <= '0;
         win_cnt_q   <= '0;
         drop_cnt_q  <= '0;
         rdy_en_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         win_start_q <= win_start_d;
         pend_ts_q   <= pend_ts_d;
         pend_x_q    <= pend_x_d;
         pend_y_q    <= pend_y_d;
         pend_pol_q  <= pend_pol_d;
         stg_v_q     <= stg_v_d;
         stg_data_q  <= stg_data_d;
         win_cnt_q   <= win_cnt_d;
         drop_cnt_q  <= drop_cnt_d;
         rdy_en_q    <= 1'b1;
      end
   end

   assign push = stg_v_q;
   assign pop  = out_valid && out_ready;

   // FIFO pointers; the extra MSB separates full from empty.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   // FIFO storage; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q[AW-1:0]] <= stg_data_q;
   end

   assign rd_data     = mem_q[rd_ptr_q[AW-1:0]];
   assign out_valid   = !fifo_empty;
   assign out_x       = out_valid ? rd_data[TIME_OUT_BIT+1+INPUT_BIT_Y +: INPUT_BIT_X] : '0;
   assign out_y       = out_valid ? rd_data[TIME_OUT_BIT+1 +: INPUT_BIT_Y] : '0;
   assign out_pol     = out_valid && rd_data[TIME_OUT_BIT];
   assign out_dt      = out_valid ? rd_data[TIME_OUT_BIT-1:0] : '0;
   assign in_ready    = in_ready_c;
   assign window_done = (state_q == ST_START);
   assign window_cnt  = win_cnt_q;
   assign drop_cnt    = drop_cnt_q;

endmodule

// File: doc/event_window_ingress.md
Name: event_window_ingress

Overview:
- Parametrised event front-end that sits between the DVS event inputs and the graph-building pipeline inside top.
- Validates coordinates and discards non-monotonic events.
- Converts absolute timestamps to time relative to the current accumulation window.
- Buffers accepted events in a FIFO with a valid/ready output, and marks window boundaries so downstream logic can close a graph per window.

Parameters:
- MAX_X_COORD, 240: exclusive upper bound on x.
- MAX_Y_COORD, 180: exclusive upper bound on y.
- INPUT_BIT_TIME, 32: absolute timestamp width, in µs.
- INPUT_BIT_X, 8: x coordinate width.
- INPUT_BIT_Y, 8: y coordinate width.
- WINDOW_US, 50000: window length in µs. Must be at least 1.
- TIME_OUT_BIT, 16: relative timestamp width. Must be at least $clog2(WINDOW_US).
- FIFO_DEPTH, 16: buffer entries. Must be a power of 2 and at least 2.
- CNT_BIT, 16: width of the drop and window counters.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- timestamp  in  INPUT_BIT_TIME  absolute event time.
- x_coord  in  INPUT_BIT_X  event x.
- y_coord  in  INPUT_BIT_Y  event y.
- polarity  in  1  event polarity.
- is_valid  in  1  input event valid.
- in_ready  out  1  block can accept an event this cycle.
- out_x  out  INPUT_BIT_X  buffered x.
- out_y  out  INPUT_BIT_Y  buffered y.
- out_pol  out  1  buffered polarity.
- out_dt  out  TIME_OUT_BIT  timestamp minus window start.
- out_valid  out  1  output event valid.
- out_ready  in  1  downstream accepts the output event.
- window_done  out  1  one-cycle pulse when a window is closed and fully drained.
- window_cnt  out  CNT_BIT  number of windows closed; wraps.
- drop_cnt  out  CNT_BIT  number of events discarded; saturates at all-ones.

Behaviour:
- Reset (reset=0, asynchronous): all outputs go to 0, the FIFO is emptied, the state goes to IDLE and window_start goes to 0. On the cycle after reset is released, in_ready=1.
- Handshake and filter:
  - An event is accepted when is_valid && in_ready.
  - An accepted event is dropped if x_coord >= MAX_X_COORD or y_coord >= MAX_Y_COORD.
  - In OPEN, an accepted event is also dropped if timestamp < window_start.
  - Each drop increments drop_cnt, saturating.
  - A dropped event never alters the window state.
- in_ready = state is IDLE or OPEN and FIFO not full. No event is lost because of backpressure; upstream holds the event.
- FSM states:
  - IDLE: no window. The first non-dropped event sets window_start=timestamp, is written with dt=0, and moves the state to OPEN.
  - OPEN:
    - Compute delta = timestamp - window_start, full INPUT_BIT_TIME width.
    - If delta < WINDOW_US: write the event with dt=delta[TIME_OUT_BIT-1:0].
    - If delta >= WINDOW_US: capture the event in a pending register, do not write it, and go to DRAIN.
  - DRAIN: in_ready=0. Wait until the FIFO is empty and there is no out_valid, then go to START.
  - START:
    - Pulse window_done for exactly this one cycle and increment window_cnt.
    - Set window_start = pending timestamp, write the pending event with dt=0, then go to OPEN.
    - in_ready=0 in this cycle.
- Latency: an event accepted in cycle N is registered in N+1 and written to the FIFO. It is visible on out_valid in N+2 if the FIFO was empty.
- Output side:
  - Show-ahead FIFO: the out_* signals are valid whenever out_valid=1.
  - Pop on out_valid && out_ready.
  - While out_valid=1 and out_ready=0, the out_* signals are held stable.
- FIFO pointers are $clog2(FIFO_DEPTH)+1 bits wide, with full/empty detected from the MSB. A simultaneous push and pop keeps the occupancy unchanged. A push while full cannot occur, by construction.
- Timestamp wrap: an event with timestamp < window_start is treated as non-monotonic and dropped. No wrap recovery is provided.
- If delta equals WINDOW_US exactly, the event starts a new window.
- Reset mid-window: all contents are discarded, no window_done is produced, and window_cnt returns to 0.

Test Plan:
- Reset then events (10,20,1,t=100), (11,21,0,t=150), out_ready=1 → out_valid in cycles N+2 and N+3, out_dt=0 then 50, drop_cnt=0.
- Event x=240,y=5 and event x=3,y=180 → both dropped, drop_cnt=2, no out_valid, state stays IDLE.
- Window start t=1000; events at t=50999 and t=51000 → the first is output with dt=49999; the second triggers DRAIN, then a window_done pulse once the FIFO is empty, window_cnt=1, and the second is output with dt=0.
- Hold out_ready=0 and push 17 events with FIFO_DEPTH=16 → in_ready=0 after 16 writes and the 17th is held upstream. Releasing out_ready drains all 17 in order with stable data during stall.
- Window start t=500, then event t=400 → dropped, drop_cnt increments, window_start remains 500. Drive enough drops to reach drop_cnt saturation → it stays at 0xFFFF.
- Assert reset during DRAIN with 5 buffered events → out_valid=0 and in_ready=0 during reset, in_ready=1 on the cycle after release, FIFO empty, window_cnt=0, no window_done pulse.
